mole_whack_capture: RTL and testbench

//   Captures player "whacks" against the mole state that the processor writes into the
//   8-bit mole register. Raw buttons are synchronised, debounced and edge-detected, then

---
 rtl/mole_whack_capture.sv | 140 ++++++++++++++
 tb/tb_mole_whack_capture.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_whack_capture.sv
// mole_whack_capture: synchronises, debounces and edge-detects player buttons,
// classifies each press against the mole register as a hit or a miss, holds
// results in sticky pending registers until the processor collects them over a
// 4-phase req/ack handshake, and keeps a saturating hit counter for scoring.
module mole_whack_capture #(
  parameter int N          = 8,
  parameter int DEB_CYCLES = 4,
  parameter int CW         = 8
) (
  input  logic          i_clk,
  input  logic          i_clr_n,
  input  logic [N-1:0]  i_btn,
  input  logic [N-1:0]  i_mole_up,
  input  logic          i_rd_req,
  output logic          o_rd_ack,
  output logic [N-1:0]  o_hit_mask,
  output logic [N-1:0]  o_miss_mask,
  output logic          o_irq,
  input  logic          i_cnt_clr,
  output logic [CW-1:0] o_hit_count
);

  localparam int DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PW  = $clog2(N + 1);
  localparam logic [DCW-1:0] DC_LAST = DCW'(DEB_CYCLES - 1);
  localparam logic [CW:0]    CNT_MAX = {1'b0, {CW{1'b1}}};

  typedef enum logic {S_IDLE, S_ACK} state_t;

  logic [N-1:0]   r_s1;
  logic [N-1:0]   r_s2;
  logic [DCW-1:0] r_dc [N];
  logic [N-1:0]   r_deb;
  logic [N-1:0]   r_deb_d;
  logic [N-1:0]   r_hit_pend;
  logic [N-1:0]   r_miss_pend;
  logic [CW-1:0]  r_hit_count;
  state_t         r_state;

  logic [N-1:0]   w_press;
  logic [N-1:0]   w_hit_ev;
  logic [N-1:0]   w_miss_ev;
  logic [PW-1:0]  w_pop;
  logic [CW-1:0]  w_base;
  logic [CW:0]    w_sum;
  logic [CW-1:0]  w_cnt_next;

  // Two-flop synchroniser bringing the asynchronous buttons into the clock domain
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
    end
  end

  // Per-bit debouncer: the level follows s2 only after DEB_CYCLES disagreeing cycles
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      for (int i = 0; i < N; i++) r_dc[i] <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
    end else begin
      r_deb_d <= r_deb;
      for (int i = 0; i < N; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_dc[i] <= '0;
        end else if (r_dc[i] == DC_LAST) begin
          r_deb[i] <= r_s2[i];
          r_dc[i]  <= '0;
        end else begin
          r_dc[i] <= r_dc[i] + 1'b1;
        end
      end
    end
  end

  // One-cycle press pulse on each debounced rising edge, classified against the moles
  assign w_press   = r_deb & ~r_deb_d;
  assign w_hit_ev  = w_press & i_mole_up;
  assign w_miss_ev = w_press & ~i_mole_up;

  // Hit popcount and saturating next count; a clear discards the old total only
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N; i++) w_pop = w_pop + PW'(w_hit_ev[i]);
    w_base     = i_cnt_clr ? '0 : r_hit_count;
    w_sum      = {1'b0, w_base} + (CW+1)'(w_pop);
    w_cnt_next = (w_sum > CNT_MAX) ? {CW{1'b1}} : w_sum[CW-1:0];
  end

  // Score register
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) r_hit_count <= '0;
    else          r_hit_count <= w_cnt_next;
  end

  // Read handshake FSM with the sticky pending registers it snapshots and clears
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_state     <= S_IDLE;
      o_rd_ack    <= 1'b0;
      o_hit_mask  <= '0;
      o_miss_mask <= '0;
      r_hit_pend  <= '0;
      r_miss_pend <= '0;
    end else begin
      r_hit_pend  <= r_hit_pend | w_hit_ev;
      r_miss_pend <= r_miss_pend | w_miss_ev;
      case (r_state)
        S_IDLE: begin
          if (i_rd_req) begin
            o_hit_mask  <= r_hit_pend;
            o_miss_mask <= r_miss_pend;
            r_hit_pend  <= w_hit_ev;
            r_miss_pend <= w_miss_ev;
            o_rd_ack    <= 1'b1;
            r_state     <= S_ACK;
          end
        end
        S_ACK: begin
          if (!i_rd_req) begin
            o_rd_ack <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          o_rd_ack <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign o_irq       = (|r_hit_pend) | (|r_miss_pend);
  assign o_hit_count = r_hit_count;

endmodule

// File: tb/tb_mole_whack_capture.sv
// Testbench for mole_whack_capture: table-driven vectors, hand-written corner
// sequences and randomized traffic, all checked against a windowed reference model.
module tb_mole_whack_capture;

  localparam int N   = 8;
  localparam int DEB = 4;
  localparam int CW  = 8;

  logic          clk;
  logic          clrN;
  logic [N-1:0]  btn;
  logic [N-1:0]  moleUp;
  logic          rdReq;
  logic          rdAck;
  logic [N-1:0]  hitMask;
  logic [N-1:0]  missMask;
  logic          irq;
  logic          cntClr;
  logic [CW-1:0] hitCount;

  int totalChecks = 0;
  int passChecks  = 0;

  // Reference model state: debounced level as a window over past synced samples
  logic [N-1:0] hist[$];
  logic [N-1:0] mDeb, mDebD, mHitPend, mMissPend, mHitMask, mMissMask;
  logic         mAck;
  int           mCnt;

  typedef struct {
    logic [N-1:0] btn;
    logic [N-1:0] mole;
    logic         req;
    logic         clr;
    int           n;
    logic         eAck;
    logic [N-1:0] eHit;
    logic [N-1:0] eMiss;
    logic         eIrq;
    logic [CW-1:0] eCnt;
  } vec_t;

  vec_t vecs[13];

  mole_whack_capture #(.N(N), .DEB_CYCLES(DEB), .CW(CW)) dut (
    .i_clk       (clk),
    .i_clr_n     (clrN),
    .i_btn       (btn),
    .i_mole_up   (moleUp),
    .i_rd_req    (rdReq),
    .o_rd_ack    (rdAck),
    .o_hit_mask  (hitMask),
    .o_miss_mask (missMask),
    .o_irq       (irq),
    .i_cnt_clr   (cntClr),
    .o_hit_count (hitCount)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    hist.delete();
    for (int k = 0; k < DEB + 2; k++) hist.push_back('0);
    mDeb = '0; mDebD = '0; mHitPend = '0; mMissPend = '0;
    mHitMask = '0; mMissMask = '0; mAck = 1'b0; mCnt = 0;
  endtask

  // One clock edge of the model: the synced sample seen at edge k is btn from edge k-2,
  // and a level flips once the last DEB synced samples all disagree with it
  task automatic modelEdge();
    logic [N-1:0] press, hitEv, missEv, flip;
    int base, sum;
    bit allDiff;
    if (!clrN) begin
      modelReset();
      return;
    end
    press  = mDeb & ~mDebD;
    hitEv  = press & moleUp;
    missEv = press & ~moleUp;
    flip   = '0;
    for (int i = 0; i < N; i++) begin
      allDiff = 1'b1;
      for (int k = 1; k <= DEB; k++) if (hist[k][i] == mDeb[i]) allDiff = 1'b0;
      flip[i] = allDiff;
    end
    base = cntClr ? 0 : mCnt;
    sum  = base + $countones(hitEv);
    mCnt = (sum > 255) ? 255 : sum;
    if (!mAck && rdReq) begin
      mHitMask  = mHitPend;
      mMissMask = mMissPend;
      mHitPend  = hitEv;
      mMissPend = missEv;
      mAck      = 1'b1;
    end else begin
      mHitPend  = mHitPend | hitEv;
      mMissPend = mMissPend | missEv;
      if (mAck && !rdReq) mAck = 1'b0;
    end
    mDebD = mDeb;
    mDeb  = mDeb ^ flip;
    hist.push_front(btn);
    void'(hist.pop_back());
  endtask

  task automatic checkOutput(input string name, input logic eAck, input logic [N-1:0] eHit,
                             input logic [N-1:0] eMiss, input logic eIrq, input logic [CW-1:0] eCnt);
    totalChecks++;
    if (rdAck === eAck && hitMask === eHit && missMask === eMiss && irq === eIrq && hitCount === eCnt) begin
      passChecks++;
    end else begin
      $display("[TB] FAIL %s: got ack=%b hit=%h miss=%h irq=%b cnt=%h, expected ack=%b hit=%h miss=%h irq=%b cnt=%h",
               name, rdAck, hitMask, missMask, irq, hitCount, eAck, eHit, eMiss, eIrq, eCnt);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, mAck, mHitMask, mMissMask, (|mHitPend) | (|mMissPend), CW'(mCnt));
  endtask

  // Advance one edge, update the model, then sample outputs just after the edge
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
    checkModel("model");
  endtask

  task automatic doReset();
    clrN = 1'b0; btn = '0; moleUp = '0; rdReq = 1'b0; cntClr = 1'b0;
    modelReset();
    repeat (2) applyStimulus();
    checkOutput("reset", 1'b0, '0, '0, 1'b0, '0);
    clrN = 1'b1;
  endtask

  // Hold a button pattern long enough to classify on the 7th edge, then release
  task automatic pressPattern(input logic [N-1:0] pattern, input logic [N-1:0] mole, input logic clrAtClassify);
    moleUp = mole;
    btn    = pattern;
    repeat (6) applyStimulus();
    cntClr = clrAtClassify;
    applyStimulus();
    cntClr = 1'b0;
    btn    = '0;
    repeat (8) applyStimulus();
  endtask

  initial begin
    int holdCnt;
    // Glitch, then held press on bit 5 (miss), then clean hit on bit 2, then a read
    vecs[0]  = '{8'h20, 8'h00, 1'b0, 1'b0, 3,  1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{8'h00, 8'h00, 1'b0, 1'b0, 10, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[2]  = '{8'h20, 8'h00, 1'b0, 1'b0, 6,  1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[3]  = '{8'h20, 8'h00, 1'b0, 1'b0, 1,  1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
    vecs[4]  = '{8'h20, 8'h00, 1'b0, 1'b0, 1,  1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
    vecs[5]  = '{8'h00, 8'h00, 1'b0, 1'b0, 10, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
    vecs[6]  = '{8'h04, 8'h04, 1'b0, 1'b0, 6,  1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
    vecs[7]  = '{8'h04, 8'h04, 1'b0, 1'b0, 1,  1'b0, 8'h00, 8'h00, 1'b1, 8'h01};
    vecs[8]  = '{8'h04, 8'h04, 1'b0, 1'b0, 3,  1'b0, 8'h00, 8'h00, 1'b1, 8'h01};
    vecs[9]  = '{8'h00, 8'h04, 1'b0, 1'b0, 10, 1'b0, 8'h00, 8'h00, 1'b1, 8'h01};
    vecs[10] = '{8'h00, 8'h04, 1'b1, 1'b0, 1,  1'b1, 8'h04, 8'h20, 1'b0, 8'h01};
    vecs[11] = '{8'h00, 8'h04, 1'b1, 1'b0, 2,  1'b1, 8'h04, 8'h20, 1'b0, 8'h01};
    vecs[12] = '{8'h00, 8'h04, 1'b0, 1'b0, 1,  1'b0, 8'h04, 8'h20, 1'b0, 8'h01};

    doReset();
    for (int v = 0; v < 13; v++) begin
      btn = vecs[v].btn; moleUp = vecs[v].mole; rdReq = vecs[v].req; cntClr = vecs[v].clr;
      repeat (vecs[v].n) applyStimulus();
      checkOutput($sformatf("vec%0d", v), vecs[v].eAck, vecs[v].eHit, vecs[v].eMiss,
                  vecs[v].eIrq, vecs[v].eCnt);
    end

    // Hit classified on the same edge as IDLE->ACK stays pending for the next read
    doReset();
    moleUp = 8'h01; btn = 8'h01;
    repeat (6) applyStimulus();
    rdReq = 1'b1;
    applyStimulus();
    checkOutput("sameCycleRead", 1'b1, 8'h00, 8'h00, 1'b1, 8'h01);
    btn = '0;
    applyStimulus();
    rdReq = 1'b0;
    applyStimulus();
    checkOutput("ackDrop", 1'b0, 8'h00, 8'h00, 1'b1, 8'h01);
    rdReq = 1'b1;
    applyStimulus();
    checkOutput("secondRead", 1'b1, 8'h01, 8'h00, 1'b0, 8'h01);
    rdReq = 1'b0;
    applyStimulus();

    // Saturation at the top of the counter, then clear with a same-cycle hit
    doReset();
    for (int p = 0; p < 31; p++) pressPattern(8'hFF, 8'hFF, 1'b0);
    pressPattern(8'h3F, 8'hFF, 1'b0);
    checkOutput("count254", 1'b0, 8'h00, 8'h00, 1'b1, 8'hFE);
    pressPattern(8'h03, 8'hFF, 1'b0);
    checkOutput("countSat", 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF);
    pressPattern(8'h01, 8'hFF, 1'b0);
    checkOutput("countStay", 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF);
    pressPattern(8'h01, 8'hFF, 1'b1);
    checkOutput("clrWithHit", 1'b0, 8'h00, 8'h00, 1'b1, 8'h01);

    // Asynchronous reset in the middle of a handshake with events pending
    doReset();
    pressPattern(8'h02, 8'h02, 1'b0);
    rdReq = 1'b1;
    applyStimulus();
    checkOutput("preRstAck", 1'b1, 8'h02, 8'h00, 1'b0, 8'h01);
    pressPattern(8'h08, 8'h00, 1'b0);
    checkOutput("ackAccum", 1'b1, 8'h02, 8'h00, 1'b1, 8'h01);
    #2 clrN = 1'b0;
    modelReset();
    #1;
    checkOutput("asyncRst", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    applyStimulus();
    clrN = 1'b1;
    rdReq = 1'b0;
    repeat (2) applyStimulus();
    rdReq = 1'b1;
    applyStimulus();
    checkOutput("postRstRead", 1'b1, 8'h00, 8'h00, 1'b0, 8'h00);
    rdReq = 1'b0;
    applyStimulus();

    // Randomized traffic: buttons held for random lengths to exercise the debouncer
    doReset();
    holdCnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (holdCnt == 0) begin
        btn     = N'($urandom);
        holdCnt = $urandom_range(1, 10);
      end
      holdCnt--;
      if ($urandom_range(0, 5) == 0) moleUp = N'($urandom);
      if (!rdReq && !mAck && $urandom_range(0, 15) == 0) rdReq = 1'b1;
      else if (rdReq && mAck && $urandom_range(0, 3) == 0) rdReq = 1'b0;
      cntClr = ($urandom_range(0, 63) == 0);
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
